// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss it issues 8 consecutive word reads
// for the aligned line and writes the returned words into the data array.
module cache_fill_fsm #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [2:0]        word_num,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-4:0] base_q, base_d;
  logic [3:0]        req_cnt_q, req_cnt_d;
  logic [2:0]        ret_cnt_q, ret_cnt_d;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      req_cnt_q <= 4'd0;
      ret_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    req_cnt_d        = req_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = {base_q, 3'b000};
    word_num         = ret_cnt_q;

    case (state_q)
      IDLE: begin
        // Stall already in the miss cycle so the pipeline never sees stale data.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_d   = FILL;
          base_d    = miss_address[ADDR_W-1:3];
          req_cnt_d = 4'd0;
          ret_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (req_cnt_q < 4'd8) begin
          memory_read_en = 1'b1;
          memory_address = {base_q, req_cnt_q[2:0]};
          req_cnt_d      = req_cnt_q + 4'd1;
        end else begin
          memory_read_en = 1'b0;
        end
        // Returns are counted on their own; the last one closes the line.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (ret_cnt_q == 3'd7) begin
            write_tag_array = 1'b1;
            ret_cnt_d       = 3'd0;
            state_d         = IDLE;
          end else begin
            ret_cnt_d = ret_cnt_q + 3'd1;
          end
        end else begin
          write_data_array = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the width of miss_address and memory_address.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port miss_detected, input, 1 bit: the cache reports a miss on the current access.
REQ-005 The block SHALL have port miss_address, input, ADDR_W bits: the address of the missing access.
REQ-006 The block SHALL have port memory_data_valid, input, 1 bit: main memory returns one word this cycle.
REQ-007 The block SHALL have port fsm_busy, output, 1 bit: stall request to the pipeline.
REQ-008 The block SHALL have port write_data_array, output, 1 bit: write enable for one data-array word.
REQ-009 The block SHALL have port write_tag_array, output, 1 bit: write enable for the tag/valid array.
REQ-010 The block SHALL have port word_num, output, 3 bits: index of the word being written into the cache line.
REQ-011 The block SHALL have port memory_read_en, output, 1 bit: read request to main memory.
REQ-012 The block SHALL have port memory_address, output, ADDR_W bits: word address of the read request.

Function
REQ-013 The block SHALL implement two states: IDLE and FILL.
REQ-014 IDLE -> FILL SHALL occur on a clock edge where the state is IDLE and miss_detected=1; on that edge the block SHALL latch base = miss_address[ADDR_W-1:3], clear req_cnt (0..8) and clear ret_cnt (0..7).
REQ-015 fsm_busy SHALL equal (state==FILL) | (state==IDLE & miss_detected), combinationally, so the pipeline stalls in the miss cycle itself.
REQ-016 In FILL with req_cnt<8, memory_read_en SHALL be 1, memory_address SHALL be {base, req_cnt[2:0]}, and req_cnt SHALL increment each cycle; this issues exactly 8 requests on consecutive cycles starting at the first FILL cycle.
REQ-017 With req_cnt==8, or in IDLE, memory_read_en SHALL be 0 and memory_address SHALL be {base, 3'b000}.
REQ-018 write_data_array SHALL equal (state==FILL & memory_data_valid), combinationally; word_num SHALL equal ret_cnt; ret_cnt SHALL increment on each such cycle.
REQ-019 When write_data_array=1 and ret_cnt==7, write_tag_array SHALL be 1 in that same cycle, and the state SHALL return to IDLE on the next edge; otherwise write_tag_array SHALL be 0.
REQ-020 Returns are counted independently of requests; the block SHALL tolerate any memory latency >=1 and gaps between valid cycles.
REQ-021 memory_data_valid in IDLE SHALL be ignored; no array write and no counter change.
REQ-022 miss_detected during FILL, including the final-write cycle, SHALL be ignored; a still-asserted miss SHALL start a new fill from IDLE on the following edge.
REQ-023 miss_address changes during FILL SHALL NOT affect base.
REQ-024 ret_cnt SHALL NOT wrap within a fill; the FILL -> IDLE transition terminates it.

Reset
REQ-025 While rst=1 (asynchronous), the state SHALL be IDLE, with base=0, req_cnt=0 and ret_cnt=0; write_data_array, write_tag_array, memory_read_en and word_num SHALL be 0, and memory_address SHALL be 0. fsm_busy SHALL follow REQ-015, and so is 0 while miss_detected=0.
REQ-026 Reset asserted mid-fill SHALL abort the fill with no further array writes; returns arriving after reset deassertion SHALL be ignored per REQ-021.

Verification
REQ-027 Basic fill, memory latency 4: miss_address=0x1234 in IDLE -> memory_address 0x1230..0x1237 on 8 consecutive cycles; write_data_array pulses with word_num 0..7 on FILL cycles 5..12, counting the first FILL cycle as 1; write_tag_array=1 only with word_num=7; fsm_busy then drops.
REQ-028 Gapped returns: valid on alternate cycles -> exactly 8 data writes, word_num strictly 0..7; tag write on the 8th write only.
REQ-029 Spurious valid in IDLE, plus miss_detected held high during FILL with a changing miss_address -> no writes in IDLE; no restart and base unchanged during FILL; new fill starts the cycle after the tag write.
REQ-030 Reset after the 3rd return -> all outputs 0 immediately; the remaining 5 returns produce no writes; a new miss at 0x00F8 fills 0x00F8..0x00FF.
REQ-031 Back-to-back misses at 0xFFFF then 0x0000 -> requests 0xFFF8..0xFFFF then 0x0000..0x0007, one IDLE cycle between fills.
